// File: rtl/fifo_ctrl_pkg.sv
// Shared constants for the FIFO read/write controller: default widths,
// depth, and pointer/count types.
package fifo_ctrl_pkg;

   localparam int DATA_W_DEF     = 4;
   localparam int DEPTH_LOG2_DEF = 3;
   localparam int RAM_AW_DEF     = 8;
   localparam int DEPTH          = 1 << DEPTH_LOG2_DEF;
   localparam int PTR_W          = DEPTH_LOG2_DEF;
   localparam int CNT_W          = DEPTH_LOG2_DEF + 1;

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/fifo_rd_wr_ctrl_if.sv
// Push/pop handshake and RAM port bundle for fifo_rd_wr_ctrl.
// slave  = the controller, master = the surrounding logic (source, sink and RAM).
interface fifo_rd_wr_ctrl_if
   import fifo_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RAM_AW = RAM_AW_DEF
) ();

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              ram_wr_en;
   logic [RAM_AW-1:0] ram_wr_addr;
   logic [DATA_W-1:0] ram_wr_data;
   logic              ram_rd_en;
   logic [RAM_AW-1:0] ram_rd_addr;
   logic [DATA_W-1:0] ram_rd_data;

   modport slave (
      input  in_valid, in_data, out_ready, ram_rd_data,
      output in_ready, out_valid, out_data,
      output ram_wr_en, ram_wr_addr, ram_wr_data,
      output ram_rd_en, ram_rd_addr
   );

   modport master (
      output in_valid, in_data, out_ready, ram_rd_data,
      input  in_ready, out_valid, out_data,
      input  ram_wr_en, ram_wr_addr, ram_wr_data,
      input  ram_rd_en, ram_rd_addr
   );

endinterface

// File: rtl/fifo_ptr_cnt.sv
// Wrapping W-bit pointer with increment enable; wraps naturally modulo 2**W.
module fifo_ptr_cnt
   import fifo_ctrl_pkg::*;
#(
   parameter int W = PTR_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   // advance the pointer on each enabled cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + W'(1);
      end
   end

endmodule

// File: rtl/fifo_rd_wr_ctrl.sv
// FIFO controller in front of a two-port RAM with a registered read port.
// The RAM read register is the output data stage; ov marks it valid
// (first-word-fall-through pop side).
// Optional feature macro: FIFO_CTRL_WATERMARK_EN adds a registered
// almost_full output (count >= AF_THRESH).
module fifo_rd_wr_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
   parameter int RAM_AW     = RAM_AW_DEF,
   parameter int AF_THRESH  = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   fifo_rd_wr_ctrl_if.slave    bus,
   output logic [DEPTH_LOG2:0] count,
   output logic                full,
   output logic                empty
`ifdef FIFO_CTRL_WATERMARK_EN
   ,
   output logic                almost_full
`endif
);

   localparam int CW      = DEPTH_LOG2 + 1;
   localparam int DEPTH_N = 1 << DEPTH_LOG2;

   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [CW-1:0]         mem_cnt_q;
   logic [CW-1:0]         mem_cnt_nxt;
   logic [CW-1:0]         count_nxt;
   logic                  ov_q;
   logic                  ov_nxt;
   logic                  full_q;
   logic                  empty_q;
   logic                  push;
   logic                  rd;
   logic                  pop;

   // handshake decode and next-state occupancy; a read is never issued
   // against an entry written on the same edge because mem_cnt is registered
   always_comb begin
      push        = bus.in_valid && !full_q;
      rd          = (mem_cnt_q != '0) && (!ov_q || bus.out_ready);
      pop         = ov_q && bus.out_ready;
      ov_nxt      = ov_q;
      if (rd) begin
         ov_nxt = 1'b1;
      end else if (pop) begin
         ov_nxt = 1'b0;
      end
      mem_cnt_nxt = mem_cnt_q + CW'(push) - CW'(rd);
      count_nxt   = mem_cnt_nxt + CW'(ov_nxt);
   end

   fifo_ptr_cnt #(.W(DEPTH_LOG2)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (push),
      .ptr   (wr_ptr)
   );

   fifo_ptr_cnt #(.W(DEPTH_LOG2)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (rd),
      .ptr   (rd_ptr)
   );

   // occupancy, output-valid flag and registered status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_cnt_q <= '0;
         ov_q      <= 1'b0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
      end else begin
         mem_cnt_q <= mem_cnt_nxt;
         ov_q      <= ov_nxt;
         full_q    <= (mem_cnt_nxt == CW'(DEPTH_N));
         empty_q   <= (count_nxt == '0);
      end
   end

`ifdef FIFO_CTRL_WATERMARK_EN
   // watermark flag tracks the next total occupancy so it is registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         almost_full <= 1'b0;
      end else begin
         almost_full <= (count_nxt >= CW'(AF_THRESH));
      end
   end
`else
   logic unused_af_thresh;
   assign unused_af_thresh = (AF_THRESH != 0);
`endif

   assign bus.in_ready    = !full_q;
   assign bus.out_valid   = ov_q;
   assign bus.out_data    = DATA_W'(bus.ram_rd_data);
   assign bus.ram_wr_en   = push;
   assign bus.ram_wr_addr = {{(RAM_AW-DEPTH_LOG2){1'b0}}, wr_ptr};
   assign bus.ram_wr_data = DATA_W'(bus.in_data);
   assign bus.ram_rd_en   = rd;
   assign bus.ram_rd_addr = {{(RAM_AW-DEPTH_LOG2){1'b0}}, rd_ptr};
   assign count           = mem_cnt_q + CW'(ov_q);
   assign full            = full_q;
   assign empty           = empty_q;

endmodule

// File: tb/tb_fifo_rd_wr_ctrl.sv
// Testbench for fifo_rd_wr_ctrl: behavioural RAM, queue-based reference
// model with scoreboard, independent pop monitor, directed and random stimulus.
module tb_fifo_rd_wr_ctrl;
   import fifo_ctrl_pkg::*;

   localparam int AF = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fifo_rd_wr_ctrl_if #(.DATA_W(DATA_W_DEF), .RAM_AW(RAM_AW_DEF)) bus ();

   logic [DEPTH_LOG2_DEF:0] count;
   logic                    full;
   logic                    empty;
`ifdef FIFO_CTRL_WATERMARK_EN
   logic                    almost_full;
`endif

   fifo_rd_wr_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .count (count),
      .full  (full),
      .empty (empty)
`ifdef FIFO_CTRL_WATERMARK_EN
      ,
      .almost_full (almost_full)
`endif
   );

   // RAM: registered read, holds its read register when not enabled
   logic [3:0] ram_mem [256];
   logic [3:0] ram_rd_q;
   always @(posedge clk) begin
      if (bus.ram_wr_en) ram_mem[bus.ram_wr_addr] <= bus.ram_wr_data;
      if (bus.ram_rd_en) ram_rd_q <= ram_mem[bus.ram_rd_addr];
   end
   assign bus.ram_rd_data = ram_rd_q;

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endfunction

   // reference model: words sitting in RAM, the output stage flag, write/read totals
   logic [3:0] ram_q[$];
   logic [3:0] exp_q[$];
   bit         stage_v;
   int         wr_total;
   int         rd_total;

   // reference model: check status/enables, then advance by one clock edge
   always @(negedge clk) begin
      int sz;
      int occ;
      bit acc;
      bit rdm;
      bit popm;
      if (!rst_n) begin
         ram_q.delete();
         exp_q.delete();
         stage_v  = 1'b0;
         wr_total = 0;
         rd_total = 0;
         chk("rst_in_ready", bus.in_ready, 1);
         chk("rst_out_valid", bus.out_valid, 0);
         chk("rst_full", full, 0);
         chk("rst_empty", empty, 1);
         chk("rst_count", count, 0);
         chk("rst_wr_en", bus.ram_wr_en, 0);
         chk("rst_rd_en", bus.ram_rd_en, 0);
         chk("rst_wr_addr", bus.ram_wr_addr, 0);
         chk("rst_rd_addr", bus.ram_rd_addr, 0);
`ifdef FIFO_CTRL_WATERMARK_EN
         chk("rst_almost_full", almost_full, 0);
`endif
      end else begin
         sz   = ram_q.size();
         occ  = sz + int'(stage_v);
         acc  = bus.in_valid && (sz < DEPTH);
         rdm  = (sz > 0) && (!stage_v || bus.out_ready);
         popm = stage_v && bus.out_ready;
         chk("in_ready", bus.in_ready, sz < DEPTH);
         chk("full", full, sz == DEPTH);
         chk("empty", empty, occ == 0);
         chk("count", count, occ);
         chk("out_valid", bus.out_valid, stage_v);
         chk("ram_wr_en", bus.ram_wr_en, acc);
         chk("ram_rd_en", bus.ram_rd_en, rdm);
         if (acc) begin
            chk("ram_wr_addr", bus.ram_wr_addr, wr_total % DEPTH);
            chk("ram_wr_data", bus.ram_wr_data, bus.in_data);
         end
         if (rdm) chk("ram_rd_addr", bus.ram_rd_addr, rd_total % DEPTH);
`ifdef FIFO_CTRL_WATERMARK_EN
         chk("almost_full", almost_full, occ >= AF);
`endif
         if (rdm) begin
            void'(ram_q.pop_front());
            stage_v = 1'b1;
            rd_total++;
         end else if (popm) begin
            stage_v = 1'b0;
         end
         if (acc) begin
            ram_q.push_back(bus.in_data);
            exp_q.push_back(bus.in_data);
            wr_total++;
         end
      end
   end

   // monitor: every completed pop must match the oldest accepted push
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         chk("sb_has_entry", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) chk("out_data", bus.out_data, exp_q.pop_front());
      end
   end

   task automatic drive(input bit v, input logic [3:0] d, input bit r);
      @(posedge clk);
      #1;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = r;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int vp;
      int rp;
      bus.in_valid  = 1'b0;
      bus.in_data   = 4'h0;
      bus.out_ready = 1'b0;
      rst_n         = 1'b0;
      repeat (3) drive(0, 4'h0, 0);
      rst_n = 1'b1;

      // idle after reset release
      repeat (5) drive(0, 4'h0, 1);
      @(negedge clk);
      chk("idle_in_ready", bus.in_ready, 1);
      chk("idle_empty", empty, 1);
      chk("idle_rd_en", bus.ram_rd_en, 0);

      // single push latency
      drive(1, 4'hA, 1);
      @(negedge clk);
      chk("lat_wr_en", bus.ram_wr_en, 1);
      chk("lat_wr_addr", bus.ram_wr_addr, 0);
      drive(0, 4'h0, 1);
      @(negedge clk);
      chk("lat_rd_en", bus.ram_rd_en, 1);
      chk("lat_rd_addr", bus.ram_rd_addr, 0);
      drive(0, 4'h0, 1);
      @(negedge clk);
      chk("lat_out_valid", bus.out_valid, 1);
      chk("lat_out_data", bus.out_data, 4'hA);
      drive(0, 4'h0, 1);
      @(negedge clk);
      chk("lat_empty_after", empty, 1);

      // fill to capacity, 10 must be refused, then drain across the wrap
      for (int i = 1; i <= 10; i++) drive(1, 4'(i), 0);
      @(negedge clk);
      chk("fill_count", count, 9);
      chk("fill_full", full, 1);
      chk("fill_in_ready", bus.in_ready, 0);
      drive(0, 4'h0, 0);
      repeat (12) drive(0, 4'h0, 1);
      @(negedge clk);
      chk("drain_count", count, 0);
      chk("drain_sb_empty", exp_q.size(), 0);

      // backpressure: head stays put and no read is issued
      drive(1, 4'h5, 0);
      drive(1, 4'h6, 0);
      drive(0, 4'h0, 0);
      drive(0, 4'h0, 0);
      for (int i = 0; i < 5; i++) begin
         drive(0, 4'h0, 0);
         @(negedge clk);
         chk("bp_out_valid", bus.out_valid, 1);
         chk("bp_out_data", bus.out_data, 4'h5);
         chk("bp_rd_en", bus.ram_rd_en, 0);
      end
      repeat (4) drive(0, 4'h0, 1);

      // sustained one push and one pop per cycle
      for (int i = 0; i < 16; i++) begin
         drive(1, 4'(i), 1);
         if (i == 8) begin
            @(negedge clk);
            chk("steady_count", count, 2);
         end
      end
      repeat (4) drive(0, 4'h0, 1);

      // reset with queued data: nothing queued may come out afterwards
      for (int i = 0; i < 5; i++) drive(1, 4'(i + 8), 0);
      drive(0, 4'h0, 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_count", count, 0);
      chk("midrst_out_valid", bus.out_valid, 0);
      repeat (2) drive(0, 4'h0, 0);
      rst_n = 1'b1;
      drive(1, 4'h3, 1);
      drive(0, 4'h0, 1);
      drive(0, 4'h0, 1);
      @(negedge clk);
      chk("postrst_out_valid", bus.out_valid, 1);
      chk("postrst_out_data", bus.out_data, 4'h3);
      repeat (4) drive(0, 4'h0, 1);

      // randomized traffic with varying push/pop bias
      vp = 50;
      rp = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) begin
            vp = 10 + int'($urandom_range(85));
            rp = 10 + int'($urandom_range(85));
         end
         drive(int'($urandom_range(99)) < vp, 4'($urandom), int'($urandom_range(99)) < rp);
      end
      repeat (15) drive(0, 4'h0, 1);
      @(negedge clk);
      chk("final_sb_empty", exp_q.size(), 0);
      chk("final_count", count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
